// File: rtl/multi_channel_pulse_scheduler.sv
// Multi-channel pulse scheduler: per-channel descriptor FIFOs released on a shared 32-bit timebase.
// Optional macro PULSE_SCHED_LATE_DROP_EN: late heads are discarded instead of being issued.
module multi_channel_pulse_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 8,
    parameter int FREQ_W  = 32,
    parameter int PHASE_W = 16,
    parameter int AMP_W   = 16,
    parameter int ENV_W   = 10,
    parameter int TLEN_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [$clog2(NUM_CH):0]     s_ch,
    input  logic [FREQ_W-1:0]           s_freq,
    input  logic [PHASE_W-1:0]          s_phase,
    input  logic [AMP_W-1:0]            s_amp,
    input  logic [ENV_W-1:0]            s_env,
    input  logic [31:0]                 s_tstart,
    input  logic [TLEN_W-1:0]           s_tlen,
    output logic [31:0]                 counter,
    output logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH-1:0]           ch_ready,
    output logic [NUM_CH*FREQ_W-1:0]    ch_freq,
    output logic [NUM_CH*PHASE_W-1:0]   ch_phase,
    output logic [NUM_CH*AMP_W-1:0]     ch_amp,
    output logic [NUM_CH*ENV_W-1:0]     ch_env,
    output logic [NUM_CH*TLEN_W-1:0]    ch_tlen,
    output logic [NUM_CH-1:0]           ch_busy,
    output logic [NUM_CH-1:0]           ch_full,
    output logic [NUM_CH-1:0]           ch_empty,
    output logic [NUM_CH-1:0]           late_pulse,
    output logic                        bad_ch
);
    localparam int CH_W  = $clog2(NUM_CH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [FREQ_W-1:0]  freq;
        logic [PHASE_W-1:0] phase;
        logic [AMP_W-1:0]   amp;
        logic [ENV_W-1:0]   env;
        logic [31:0]        tstart;
        logic [TLEN_W-1:0]  tlen;
    } desc_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE, ST_PLAY} state_t;

    logic [31:0]        r_counter;
    desc_t              r_mem [NUM_CH][DEPTH];
    logic [PTR_W-1:0]   r_wr [NUM_CH];
    logic [PTR_W-1:0]   r_rd [NUM_CH];
    logic [CNT_W-1:0]   r_cnt [NUM_CH];
    logic [TLEN_W-1:0]  r_play [NUM_CH];
    state_t             r_state [NUM_CH];
    state_t             w_state_next [NUM_CH];
    logic [NUM_CH-1:0]  r_late;
    logic               r_bad;
    logic [NUM_CH*FREQ_W-1:0]  r_ch_freq;
    logic [NUM_CH*PHASE_W-1:0] r_ch_phase;
    logic [NUM_CH*AMP_W-1:0]   r_ch_amp;
    logic [NUM_CH*ENV_W-1:0]   r_ch_env;
    logic [NUM_CH*TLEN_W-1:0]  r_ch_tlen;

    desc_t              w_in;
    desc_t              w_head [NUM_CH];
    logic [31:0]        w_d [NUM_CH];
    logic [NUM_CH-1:0]  w_full, w_empty, w_late, w_ontime;
    logic [NUM_CH-1:0]  w_push, w_pop, w_load, w_late_set;
    logic               w_ch_ok, w_sel_full, w_more;

    // Head-of-queue status; d = t_start - counter in modular arithmetic keeps the compare wrap-safe.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_full[c]   = (r_cnt[c] == CNT_W'(DEPTH));
            w_empty[c]  = (r_cnt[c] == '0);
            w_head[c]   = r_mem[c][r_rd[c]];
            w_d[c]      = w_head[c].tstart - r_counter;
            w_late[c]   = w_d[c][31] || (w_d[c] == 32'd0);
            w_ontime[c] = (w_d[c] == 32'd1);
        end
    end

    always_comb begin
        w_in       = {s_freq, s_phase, s_amp, s_env, s_tstart, s_tlen};
        w_ch_ok    = (s_ch < CH_W'(NUM_CH));
        w_sel_full = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (s_ch == CH_W'(c)) w_sel_full = w_full[c];
        s_ready = !w_ch_ok || !w_sel_full;
        for (int c = 0; c < NUM_CH; c++)
            w_push[c] = s_valid && s_ready && (s_ch == CH_W'(c));
    end

    // NOTE: every signal driven here gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_pop      = '0;
        w_load     = '0;
        w_late_set = '0;
        w_more     = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_next[c] = r_state[c];
            w_more = (r_cnt[c] != CNT_W'(1)) || w_push[c];
            case (r_state[c])
                ST_IDLE:
                    if (!w_empty[c]) w_state_next[c] = ST_WAIT;
                ST_WAIT:
                    if (w_late[c]) begin
                        w_late_set[c] = 1'b1;
`ifdef PULSE_SCHED_LATE_DROP_EN
                        w_pop[c]        = 1'b1;
                        w_state_next[c] = w_more ? ST_WAIT : ST_IDLE;
`else
                        w_load[c]       = 1'b1;
                        w_state_next[c] = ST_ISSUE;
`endif
                    end else if (w_ontime[c]) begin
                        w_load[c]       = 1'b1;
                        w_state_next[c] = ST_ISSUE;
                    end
                ST_ISSUE:
                    if (ch_ready[c]) begin
                        w_pop[c] = 1'b1;
                        if (w_head[c].tlen != '0) w_state_next[c] = ST_PLAY;
                        else                      w_state_next[c] = w_more ? ST_WAIT : ST_IDLE;
                    end
                ST_PLAY:
                    if (r_play[c] == TLEN_W'(1)) w_state_next[c] = w_empty[c] ? ST_IDLE : ST_WAIT;
                default:
                    w_state_next[c] = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every channel samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter  <= '0;
            r_late     <= '0;
            r_bad      <= 1'b0;
            r_ch_freq  <= '0;
            r_ch_phase <= '0;
            r_ch_amp   <= '0;
            r_ch_env   <= '0;
            r_ch_tlen  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= ST_IDLE;
                r_wr[c]    <= '0;
                r_rd[c]    <= '0;
                r_cnt[c]   <= '0;
                r_play[c]  <= '0;
            end
        end else begin
            r_counter <= r_counter + 32'd1;
            r_late    <= w_late_set;
            r_bad     <= s_valid && !w_ch_ok;
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= w_state_next[c];
                if (w_push[c]) r_wr[c] <= r_wr[c] + PTR_W'(1);
                if (w_pop[c])  r_rd[c] <= r_rd[c] + PTR_W'(1);
                r_cnt[c] <= r_cnt[c] + CNT_W'(w_push[c]) - CNT_W'(w_pop[c]);
                if (w_load[c]) begin
                    r_ch_freq[c*FREQ_W +: FREQ_W]    <= w_head[c].freq;
                    r_ch_phase[c*PHASE_W +: PHASE_W] <= w_head[c].phase;
                    r_ch_amp[c*AMP_W +: AMP_W]       <= w_head[c].amp;
                    r_ch_env[c*ENV_W +: ENV_W]       <= w_head[c].env;
                    r_ch_tlen[c*TLEN_W +: TLEN_W]    <= w_head[c].tlen;
                end
                if (r_state[c] == ST_ISSUE && ch_ready[c]) r_play[c] <= w_head[c].tlen;
                else if (r_state[c] == ST_PLAY)            r_play[c] <= r_play[c] - TLEN_W'(1);
            end
        end
    end

    // NOTE: descriptor storage has no reset; r_cnt gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (w_push[c]) r_mem[c][r_wr[c]] <= w_in;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_valid[c] = (r_state[c] == ST_ISSUE);
            ch_busy[c]  = (r_state[c] == ST_PLAY);
        end
    end

    assign counter    = r_counter;
    assign ch_full    = w_full;
    assign ch_empty   = w_empty;
    assign late_pulse = r_late;
    assign bad_ch     = r_bad;
    assign ch_freq    = r_ch_freq;
    assign ch_phase   = r_ch_phase;
    assign ch_amp     = r_ch_amp;
    assign ch_env     = r_ch_env;
    assign ch_tlen    = r_ch_tlen;

endmodule
